touch_sample_filter: RTL and testbench

- Fabric block directly upstream of the touchscreen MSS subsystem's firmware interface.
- Consumes raw 12-bit ADC conversions of the 4-wire resistive panel, delivered as a tagged X/Y sample stream.
- Averages each axis and debounces pen contact.
- Emits one filtered (x,y) coordinate per completed scan through a valid/ready register that the MSS reads over its fabric interface.

---
 rtl/touch_pkg.sv | 14 +
 rtl/touch_sample_filter_if.sv | 31 +++
 rtl/touch_axis_acc.sv | 40 ++++
 rtl/touch_sample_filter.sv | 118 +++++++++++
 tb/tb_touch_sample_filter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/touch_pkg.sv
// Shared types and constants for the touchscreen sample filter.
// Holds the scan state encoding and the axis tags carried on the sample stream.
package touch_pkg;
  localparam int DEF_DATA_W = 12;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  typedef enum logic [1:0] {
    ACC_X = 2'd0,
    ACC_Y = 2'd1,
    EMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/touch_sample_filter_if.sv
// Sample-in / coordinate-out bundle between the ADC stream, the filter and the MSS.
// The slave modport is the filter's view; master is the environment driving it.
interface touch_sample_filter_if
  import touch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              sample_valid;
  logic              sample_ready;
  logic              sample_axis;
  logic [DATA_W-1:0] sample_data;
  logic              coord_valid;
  logic              coord_ready;
  logic [DATA_W-1:0] coord_x;
  logic [DATA_W-1:0] coord_y;
  logic              pen_down;
  logic              pen_up_pulse;
  logic              seq_err_pulse;

  modport master (
    output sample_valid, sample_axis, sample_data, coord_ready,
    input  sample_ready, coord_valid, coord_x, coord_y,
    input  pen_down, pen_up_pulse, seq_err_pulse
  );

  modport slave (
    input  sample_valid, sample_axis, sample_data, coord_ready,
    output sample_ready, coord_valid, coord_x, coord_y,
    output pen_down, pen_up_pulse, seq_err_pulse
  );
endinterface

// File: rtl/touch_axis_acc.sv
// One-axis accumulator: sums 2^AVG_LOG2 samples, flags the last add, gives the truncated mean.
// o_avg includes the sample being added this cycle so the final mean is usable with zero delay.
module touch_axis_acc #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_done,
  output logic [DATA_W-1:0] o_avg
);
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum_next;

  assign w_sum_next = r_sum + (i_add ? SUM_W'(i_data) : '0);
  assign o_done     = i_add && (r_cnt == LAST);
  assign o_avg      = w_sum_next[SUM_W-1:AVG_LOG2];

  // The sum is held after the last add; the owner clears it once the scan is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_sum <= w_sum_next;
      r_cnt <= o_done ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/touch_sample_filter.sv
// Averages X/Y ADC samples per scan, debounces contact and emits one coordinate per good scan.
// Coordinate appears 1 cycle after the last Y sample; sample_ready drops while a coordinate waits.
module touch_sample_filter
  import touch_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int AVG_LOG2       = 2,
  parameter int NOTOUCH_THRESH = 64,
  parameter int DEBOUNCE       = 2,
  parameter int RELEASE_CNT    = 3
) (
  input logic                  PCLK,
  input logic                  PRESERN,
  touch_sample_filter_if.slave bus
);
  localparam int PC_W = $clog2(DEBOUNCE + 1);
  localparam int RC_W = $clog2(RELEASE_CNT + 1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(DEBOUNCE);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RELEASE_CNT);

  state_t            r_state;
  logic [PC_W-1:0]   r_press_cnt;
  logic [RC_W-1:0]   r_rel_cnt;
  logic              r_coord_vld;
  logic [DATA_W-1:0] r_coord_x;
  logic [DATA_W-1:0] r_coord_y;
  logic              r_pen_down;
  logic              r_pen_up;
  logic              r_seq_err;

  logic              w_acc, w_good, w_notouch, w_seq_err;
  logic              w_add_x, w_add_y, w_done_x, w_done_y;
  logic              w_emit_take, w_clear, w_press_hit;
  logic [RC_W-1:0]   w_rel_next;
  logic [DATA_W-1:0] w_avg_x, w_avg_y;

  assign bus.sample_ready = (r_state != EMIT);

  assign w_acc       = bus.sample_valid && bus.sample_ready;
  assign w_good      = bus.sample_data >= DATA_W'(NOTOUCH_THRESH);
  assign w_notouch   = w_acc && !w_good;
  assign w_seq_err   = w_acc && w_good &&
                       (((r_state == ACC_X) && (bus.sample_axis == AXIS_Y)) ||
                        ((r_state == ACC_Y) && (bus.sample_axis == AXIS_X)));
  assign w_add_x     = w_acc && w_good && (r_state == ACC_X) && (bus.sample_axis == AXIS_X);
  assign w_add_y     = w_acc && w_good && (r_state == ACC_Y) && (bus.sample_axis == AXIS_Y);
  assign w_emit_take = r_coord_vld && bus.coord_ready;
  // Both sums restart on anything that ends or aborts the current scan.
  assign w_clear     = w_notouch || w_seq_err || w_done_y || w_emit_take;
  assign w_rel_next  = (r_rel_cnt == RC_MAX) ? r_rel_cnt : r_rel_cnt + 1'b1;
  assign w_press_hit = (int'(r_press_cnt) + 1) >= DEBOUNCE;

  touch_axis_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_x (
    .clk(PCLK), .rst_n(PRESERN), .i_clear(w_clear), .i_add(w_add_x),
    .i_data(bus.sample_data), .o_done(w_done_x), .o_avg(w_avg_x)
  );

  touch_axis_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_y (
    .clk(PCLK), .rst_n(PRESERN), .i_clear(w_clear), .i_add(w_add_y),
    .i_data(bus.sample_data), .o_done(w_done_y), .o_avg(w_avg_y)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state     <= ACC_X;
      r_press_cnt <= '0;
      r_rel_cnt   <= '0;
      r_coord_vld <= 1'b0;
      r_coord_x   <= '0;
      r_coord_y   <= '0;
      r_pen_down  <= 1'b0;
      r_pen_up    <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_pen_up  <= 1'b0;
      r_seq_err <= w_seq_err;
      if (w_emit_take) begin
        r_coord_vld <= 1'b0;
        r_state     <= ACC_X;
      end
      if (w_notouch) begin
        r_state     <= ACC_X;
        r_press_cnt <= '0;
        r_rel_cnt   <= w_rel_next;
        if ((w_rel_next == RC_MAX) && r_pen_down) begin
          r_pen_down <= 1'b0;
          r_pen_up   <= 1'b1;
        end
      end else if (w_acc) begin
        r_rel_cnt <= '0;
        if (w_seq_err) begin
          r_state <= ACC_X;
        end else if (w_done_x) begin
          r_state <= ACC_Y;
        end else if (w_done_y) begin
          if (w_press_hit) begin
            r_press_cnt <= PC_MAX;
            r_pen_down  <= 1'b1;
            r_coord_x   <= w_avg_x;
            r_coord_y   <= w_avg_y;
            r_coord_vld <= 1'b1;
            r_state     <= EMIT;
          end else begin
            r_press_cnt <= r_press_cnt + 1'b1;
            r_state     <= ACC_X;
          end
        end
      end
    end
  end

  assign bus.coord_valid   = r_coord_vld;
  assign bus.coord_x       = r_coord_x;
  assign bus.coord_y       = r_coord_y;
  assign bus.pen_down      = r_pen_down;
  assign bus.pen_up_pulse  = r_pen_up;
  assign bus.seq_err_pulse = r_seq_err;
endmodule

// File: tb/tb_touch_sample_filter.sv
// Directed bench for touch_sample_filter: a scan-level queue model is checked every cycle,
// and literal expectations for each scenario pin the model itself.
module tb_touch_sample_filter;
  localparam int DATA_W = 12;

  logic PCLK;
  logic PRESERN;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pup    = 0;

  touch_sample_filter_if #(.DATA_W(DATA_W)) bus ();

  touch_sample_filter dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .bus     (bus.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan is four X values then four Y values, held in queues until complete.
  int  m_xs[$];
  int  m_ys[$];
  int  m_press, m_rel, m_cx, m_cy;
  bit  m_cvld, m_pen, m_pup, m_serr;

  function automatic int mean4(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / 4;
  endfunction

  task automatic model_reset();
    m_xs.delete(); m_ys.delete();
    m_press = 0; m_rel = 0; m_cx = 0; m_cy = 0;
    m_cvld = 0; m_pen = 0; m_pup = 0; m_serr = 0;
  endtask

  task automatic model_step();
    int d;
    int ax;
    m_pup  = 0;
    m_serr = 0;
    d  = int'(bus.sample_data);
    ax = (m_xs.size() < 4) ? 0 : 1;
    if (m_cvld) begin
      if (bus.coord_ready) m_cvld = 0;
    end else if (bus.sample_valid) begin
      if (d < 64) begin
        m_xs.delete(); m_ys.delete();
        m_press = 0;
        if (m_rel < 3) m_rel++;
        if (m_rel == 3 && m_pen) begin
          m_pen = 0;
          m_pup = 1;
        end
      end else begin
        m_rel = 0;
        if (int'(bus.sample_axis) != ax) begin
          m_serr = 1;
          m_xs.delete(); m_ys.delete();
        end else if (ax == 0) begin
          m_xs.push_back(d);
        end else begin
          m_ys.push_back(d);
          if (m_ys.size() == 4) begin
            if (m_press + 1 >= 2) begin
              m_press = 2; m_pen = 1; m_cvld = 1;
              m_cx = mean4(m_xs); m_cy = mean4(m_ys);
            end else begin
              m_press++;
            end
            m_xs.delete(); m_ys.delete();
          end
        end
      end
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESERN) model_reset();
    chk("sample_ready",  32'(bus.sample_ready),  32'(!m_cvld));
    chk("coord_valid",   32'(bus.coord_valid),   32'(m_cvld));
    chk("coord_x",       32'(bus.coord_x),       32'(m_cx));
    chk("coord_y",       32'(bus.coord_y),       32'(m_cy));
    chk("pen_down",      32'(bus.pen_down),      32'(m_pen));
    chk("pen_up_pulse",  32'(bus.pen_up_pulse),  32'(m_pup));
    chk("seq_err_pulse", 32'(bus.seq_err_pulse), 32'(m_serr));
    if (bus.pen_up_pulse === 1'b1) n_pup++;
    if (PRESERN) model_step();
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic ax, input int d);
    int n = 0;
    bus.sample_valid = 1'b1;
    bus.sample_axis  = ax;
    bus.sample_data  = DATA_W'(d);
    @(negedge PCLK);
    while (bus.sample_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
    @(posedge PCLK);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic scan(input int x0, x1, x2, x3, y0, y1, y2, y3);
    send(1'b0, x0); send(1'b0, x1); send(1'b0, x2); send(1'b0, x3);
    send(1'b1, y0); send(1'b1, y1); send(1'b1, y2); send(1'b1, y3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic drain();
    bus.coord_ready = 1'b1;
    @(posedge PCLK);
    #1;
    bus.coord_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    PRESERN          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_axis  = 1'b0;
    bus.sample_data  = '0;
    bus.coord_ready  = 1'b0;
    idle(3);
    chk("rst_sample_ready", 32'(bus.sample_ready), 32'd1);
    chk("rst_coord_valid",  32'(bus.coord_valid),  32'd0);
    PRESERN = 1'b1;
    idle(2);

    // Clean press: first scan only arms the debounce, second emits.
    scan(1000, 1004, 1008, 1012, 2000, 2000, 2000, 2000);
    chk("press_scan1_no_emit", 32'(bus.coord_valid), 32'd0);
    scan(1000, 1004, 1008, 1012, 2000, 2000, 2000, 2000);
    chk("press_valid", 32'(bus.coord_valid), 32'd1);
    chk("press_x",     32'(bus.coord_x),     32'd1006);
    chk("press_y",     32'(bus.coord_y),     32'd2000);
    chk("press_pen",   32'(bus.pen_down),    32'd1);

    // Backpressure: coordinate held, input stalled.
    idle(10);
    chk("bp_ready",  32'(bus.sample_ready), 32'd0);
    chk("bp_x_hold", 32'(bus.coord_x),      32'd1006);
    chk("bp_y_hold", 32'(bus.coord_y),      32'd2000);
    drain();
    chk("bp_valid_drop", 32'(bus.coord_valid),  32'd0);
    chk("bp_ready_back", 32'(bus.sample_ready), 32'd1);

    // Release after three no-touch samples.
    send(1'b0, 10); send(1'b1, 10);
    chk("rel_pen_held", 32'(bus.pen_down), 32'd1);
    send(1'b0, 10);
    chk("rel_pulse", 32'(bus.pen_up_pulse), 32'd1);
    chk("rel_pen",   32'(bus.pen_down),     32'd0);
    idle(3);
    chk("rel_pulse_count", 32'(n_pup), 32'd1);

    // Out-of-order axis in ACC_X aborts the partial scan.
    send(1'b0, 500); send(1'b0, 500);
    send(1'b1, 600);
    chk("seq_err", 32'(bus.seq_err_pulse), 32'd1);
    idle(1);
    chk("seq_err_one_cycle", 32'(bus.seq_err_pulse), 32'd0);
    scan(100, 200, 300, 403, 3000, 3001, 3002, 3003);
    chk("seq_scan1_no_emit", 32'(bus.coord_valid), 32'd0);
    scan(100, 200, 300, 403, 3000, 3001, 3002, 3003);
    chk("seq_x", 32'(bus.coord_x), 32'd250);
    chk("seq_y", 32'(bus.coord_y), 32'd3001);
    drain();

    // Glitch mid-Y restarts debounce: two full scans before the next emit.
    send(1'b0, 800); send(1'b0, 800); send(1'b0, 800); send(1'b0, 800);
    send(1'b1, 900); send(1'b1, 900);
    send(1'b1, 30);
    scan(800, 800, 800, 800, 900, 900, 900, 900);
    chk("glitch_scan1_no_emit", 32'(bus.coord_valid), 32'd0);
    scan(800, 800, 800, 800, 900, 900, 900, 900);
    chk("glitch_valid", 32'(bus.coord_valid), 32'd1);
    chk("glitch_x",     32'(bus.coord_x),     32'd800);
    chk("glitch_y",     32'(bus.coord_y),     32'd900);
    drain();

    // Reset after three Y samples: outputs clear immediately, fresh press behaves normally.
    send(1'b0, 1500); send(1'b0, 1500); send(1'b0, 1500); send(1'b0, 1500);
    send(1'b1, 2500); send(1'b1, 2500); send(1'b1, 2500);
    #2;
    PRESERN = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.coord_valid),   32'd0);
    chk("mrst_x",     32'(bus.coord_x),       32'd0);
    chk("mrst_y",     32'(bus.coord_y),       32'd0);
    chk("mrst_pen",   32'(bus.pen_down),      32'd0);
    chk("mrst_pulse", 32'(bus.pen_up_pulse),  32'd0);
    chk("mrst_ready", 32'(bus.sample_ready),  32'd1);
    @(posedge PCLK);
    @(posedge PCLK);
    #1;
    PRESERN = 1'b1;
    idle(1);
    scan(1000, 1004, 1008, 1012, 2000, 2000, 2000, 2000);
    chk("mrst_scan1_no_emit", 32'(bus.coord_valid), 32'd0);
    scan(1000, 1004, 1008, 1012, 2000, 2000, 2000, 2000);
    chk("mrst_press_x", 32'(bus.coord_x),  32'd1006);
    chk("mrst_press_y", 32'(bus.coord_y),  32'd2000);
    chk("mrst_pen_on",  32'(bus.pen_down), 32'd1);
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
